fht_wr_back: RTL

Write-back stage sitting directly downstream of the double-butterfly block in the FHT core. It takes the four registered butterfly outputs, aligns them with a delayed copy of the read address and control flags, and writes them into the four data RAM banks. It applies optional divide-by-2 scaling, bit-reverses addresses on the last stage, tracks the ping-pong page, and signals stage completion to the sequencer.

---
 rtl/fht_wr_back.sv | 98 +++++++++
 1 files changed

// File: rtl/fht_wr_back.sv
// fht_wr_back: aligns butterfly results with delayed read address/flags and writes them to the four banks,
// with optional halving, last-stage address bit reversal, ping-pong page tracking and stage-done signalling.
module fht_wr_back #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8,
  parameter int LAT   = 3
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iRD_VALID,
  input  logic [A_BIT-1:0]        iRD_ADDR,
  input  logic                    iST_END,
  input  logic                    iST_LAST,
  input  logic                    iSCALE,
  input  logic signed [D_BIT-1:0] iY_0,
  input  logic signed [D_BIT-1:0] iY_1,
  input  logic signed [D_BIT-1:0] iY_2,
  input  logic signed [D_BIT-1:0] iY_3,
  output logic                    oWR_EN,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic signed [D_BIT-1:0] oDATA_0,
  output logic signed [D_BIT-1:0] oDATA_1,
  output logic signed [D_BIT-1:0] oDATA_2,
  output logic signed [D_BIT-1:0] oDATA_3,
  output logic                    oPAGE,
  output logic                    oST_DONE,
  output logic [A_BIT:0]          oWR_CNT
);
  logic [LAT-1:0]          d_v, d_e, d_l, d_s;
  logic [A_BIT-1:0]        d_a [LAT];
  logic [A_BIT-1:0]        a_rev;
  logic signed [D_BIT-1:0] y [4];
  logic signed [D_BIT-1:0] q [4];
  logic [D_BIT:0]          s [4];
  logic                    v;
  assign v = d_v[LAT-1];
  assign y[0] = iY_0;
  assign y[1] = iY_1;
  assign y[2] = iY_2;
  assign y[3] = iY_3;
  always_comb begin
    for (int i = 0; i < A_BIT; i++) a_rev[i] = d_a[LAT-1][A_BIT-1-i];
  end
  // halving rounds toward +inf on the extended width, so the result always fits D_BIT
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      s[n] = {y[n][D_BIT-1], y[n]} + (D_BIT+1)'(1);
      q[n] = d_s[LAT-1] ? s[n][D_BIT:1] : y[n];
    end
  end
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      d_v <= '0;
      d_e <= '0;
      d_l <= '0;
      d_s <= '0;
      for (int i = 0; i < LAT; i++) d_a[i] <= '0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        d_v[i] <= d_v[i-1];
        d_e[i] <= d_e[i-1];
        d_l[i] <= d_l[i-1];
        d_s[i] <= d_s[i-1];
        d_a[i] <= d_a[i-1];
      end
      d_v[0] <= iRD_VALID;
      d_e[0] <= iRD_VALID & iST_END;
      d_l[0] <= iST_LAST;
      d_s[0] <= iSCALE;
      d_a[0] <= iRD_ADDR;
    end
  end
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oWR_EN   <= 1'b0;
      oWR_ADDR <= '0;
      oDATA_0  <= '0;
      oDATA_1  <= '0;
      oDATA_2  <= '0;
      oDATA_3  <= '0;
      oPAGE    <= 1'b0;
      oST_DONE <= 1'b0;
      oWR_CNT  <= '0;
    end else begin
      oWR_EN   <= v;
      oST_DONE <= v & d_e[LAT-1];
      oPAGE    <= oPAGE ^ oST_DONE;
      oWR_CNT  <= oST_DONE ? {{A_BIT{1'b0}}, v} : oWR_CNT + (A_BIT+1)'(v);
      if (v) begin
        oWR_ADDR <= d_l[LAT-1] ? a_rev : d_a[LAT-1];
        oDATA_0  <= q[0];
        oDATA_1  <= q[1];
        oDATA_2  <= q[2];
        oDATA_3  <= q[3];
      end
    end
  end
endmodule
